yarvi_regfile: RTL and testbench
================================

// Module: yarvi_regfile
// PURPOSE
//  Parametrised RISC-V integer register file for the RF stage; replaces the fixed 2-port RV64I file.
//  Captures the decoded insn/pc into the RF pipeline register and presents rs1/rs2 (optionally rs3)
//  one cycle later. Adds: sequential hardware clear after reset, stall/flush, same-cycle WB bypass,
//  RV32E/RV64 sizing and bad-register detection.
// PARAMETERS
//  XLEN    64  data width of registers, wb_val, rs values (32 or 64)
//  VLEN    64  pc width
//  NREG    32  architectural registers, 16 (RV32E) or 32; AW = $clog2(NREG)
//  RS3_EN  0   1: third read port from insn[31:27] (R4-type); 0: rf_rs3_val tied 0
//  BYPASS  1   1: same-cycle WB->read forwarding; 0: read returns array contents only
// PORTS
//  clock       in   1     rising-edge clock
//  reset_n     in   1     asynchronous active-low reset
//  valid       in   1     insn/pc valid this cycle
//  pc          in   VLEN  pc of insn
//  insn        in   32    instruction word; rs1=[19:15] rs2=[24:20] rs3=[31:27]
//  stall       in   1     hold RF pipeline register
//  flush       in   1     kill RF pipeline register contents
//  wb_we       in   1     writeback enable
//  wb_rd       in   5     writeback destination
//  wb_val      in   XLEN  writeback data
//  ready       out  1     register file initialised; accepting traffic
//  rf_valid    out  1     rf_* outputs carry a live instruction
//  rf_pc       out  VLEN  registered pc
//  rf_insn     out  32    registered insn
//  rf_rs1_val  out  XLEN  rs1 operand
//  rf_rs2_val  out  XLEN  rs2 operand
//  rf_rs3_val  out  XLEN  rs3 operand (0 when RS3_EN=0)
//  rf_bad_reg  out  1     registered: a used rs/rd field >= NREG (RV32E only)
// BEHAVIOUR
//  - FSM {CLEAR, RUN}. reset_n low: state=CLEAR, clr_ptr=0, ready=0, rf_valid=0, rf_pc=0, rf_insn=0,
//    captured indices=0, rf_bad_reg=0. Register array itself is not reset.
//  - CLEAR: each cycle regs[clr_ptr]<=0, clr_ptr++; at clr_ptr==NREG-1 write then go RUN.
//    ready=1 from the cycle after the last clear write, i.e. exactly NREG edges after reset_n rises.
//  - In CLEAR, valid, wb_we, stall, flush are ignored; rf_valid stays 0.
//  - reset_n asserted mid-CLEAR or mid-RUN: restart CLEAR from clr_ptr=0.
//  - RUN pipeline reg update each edge: flush -> rf_valid<=0 (other fields don't-care, held);
//    else stall -> all held; else rf_valid<=valid, rf_pc<=pc, rf_insn<=insn, indices<=insn fields.
//    flush wins over stall.
//  - Write: wb_we && wb_rd!=0 && wb_rd<NREG -> regs[wb_rd[AW-1:0]]<=wb_val at edge; independent of stall/flush.
//    wb_rd==0 or out of range: dropped.
//  - Read (combinational from captured index p): p==0 -> 0; else if BYPASS && wb_we && wb_rd==p -> wb_val;
//    else regs[p]. Stalled instruction therefore sees writes landing during the stall.
//  - Read latency: operands valid in cycle after capture, same cycle as rf_valid.
//  - rf_bad_reg (NREG=16): registered with pipeline reg; 1 if any of insn[19],[24],[11] (and [31] if RS3_EN) is set.
//    Flag only; no other effect. Always 0 when NREG=32.
//  - Index width: only low AW bits address array; bit 4 only used for bad-reg/drop checks.
// TESTING
//  - Reset: hold reset_n low 3 cycles, release -> ready=0 for 32 cycles, 1 on edge 32; all rs reads = 0.
//  - Write/read: wb x5=0x1234_5678_9abc_def0, next insn rs1=5 rs2=0 -> rf_rs1_val=0x123456789abcdef0, rf_rs2_val=0.
//  - Bypass: capture rs1=7, next cycle wb x7=0xAA -> rf_rs1_val=0xAA in that cycle (BYPASS=1); old value when BYPASS=0.
//  - Stall/flush: stall 3 cycles with valid insn -> rf_pc/rf_insn held; stall+flush together -> rf_valid=0 next cycle.
//  - x0/RV32E: wb x0=0xFF -> x0 reads 0; NREG=16 insn rs2=17 -> rf_bad_reg=1, wb x17 dropped (x1 unchanged).
//  - Reset mid-run: assert reset_n low after writes -> ready drops, after 32 cycles every register reads 0.

Source files
------------

// File: rtl/yarvi_regfile.sv
// RISC-V integer register file for the RF stage: pipeline capture of insn/pc, operand read with
// optional same-cycle writeback forwarding, sequential clear after reset and RV32E bad-register flag.
module yarvi_regfile #(
  parameter int XLEN   = 64,
  parameter int VLEN   = 64,
  parameter int NREG   = 32,
  parameter int RS3_EN = 0,
  parameter int BYPASS = 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            valid,
  input  logic [VLEN-1:0] pc,
  input  logic [31:0]     insn,
  input  logic            stall,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_val,
  output logic            ready,
  output logic            rf_valid,
  output logic [VLEN-1:0] rf_pc,
  output logic [31:0]     rf_insn,
  output logic [XLEN-1:0] rf_rs1_val,
  output logic [XLEN-1:0] rf_rs2_val,
  output logic [XLEN-1:0] rf_rs3_val,
  output logic            rf_bad_reg
);

  localparam int AW = $clog2(NREG);
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  logic [0:0]      state_r;
  logic [AW-1:0]   clr_ptr_r;
  logic            ready_r;
  logic [XLEN-1:0] regs_r [NREG];

  logic            rf_valid_r;
  logic [VLEN-1:0] rf_pc_r;
  logic [31:0]     rf_insn_r;
  logic [4:0]      rs1_idx_r;
  logic [4:0]      rs2_idx_r;
  logic [4:0]      rs3_idx_r;
  logic            rf_bad_reg_r;

  logic            run_s;
  logic            wb_ok_s;
  logic            bad_s;
  logic [XLEN-1:0] rs1_s;
  logic [XLEN-1:0] rs2_s;
  logic [XLEN-1:0] rs3_s;

  // Operand select: x0 is hardwired zero, a writeback to the same index wins over the array.
  function automatic logic [XLEN-1:0] sel_operand(input logic [4:0]      p,
                                                  input logic [XLEN-1:0] arr,
                                                  input logic            fwd,
                                                  input logic [XLEN-1:0] fwd_val);
    logic [XLEN-1:0] r;
    if (p == 5'd0) begin
      r = {XLEN{1'b0}};
    end else if (fwd) begin
      r = fwd_val;
    end else begin
      r = arr;
    end
    return r;
  endfunction

  // Control decode: run state, legal writeback, RV32E out-of-range field detection.
  always_comb begin
    run_s   = (state_r == RUN);
    wb_ok_s = run_s && wb_we && (wb_rd != 5'd0) && ({1'b0, wb_rd} < 6'(NREG));
    if (NREG == 16) begin
      bad_s = insn[19] | insn[24] | insn[11] | ((RS3_EN != 0) && insn[31]);
    end else begin
      bad_s = 1'b0;
    end
  end

  // Clear sequencer: walks every register once after reset, then enters RUN.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= CLEAR;
      clr_ptr_r <= {AW{1'b0}};
      ready_r   <= 1'b0;
    end else begin
      case (state_r)
        CLEAR: begin
          if (clr_ptr_r == AW'(NREG - 1)) begin
            state_r   <= RUN;
            clr_ptr_r <= {AW{1'b0}};
            ready_r   <= 1'b1;
          end else begin
            clr_ptr_r <= clr_ptr_r + AW'(1);
          end
        end
        RUN: begin
          state_r <= RUN;
        end
        default: begin
          state_r   <= CLEAR;
          clr_ptr_r <= {AW{1'b0}};
          ready_r   <= 1'b0;
        end
      endcase
    end
  end

  // Register array: the clear walk owns the write port until RUN; contents are not reset.
  always_ff @(posedge clock) begin
    if (!run_s) begin
      regs_r[clr_ptr_r] <= {XLEN{1'b0}};
    end else if (wb_ok_s) begin
      regs_r[wb_rd[AW-1:0]] <= wb_val;
    end
  end

  // RF pipeline register; flush has priority over stall, both ignored while clearing.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rf_valid_r   <= 1'b0;
      rf_pc_r      <= {VLEN{1'b0}};
      rf_insn_r    <= 32'd0;
      rs1_idx_r    <= 5'd0;
      rs2_idx_r    <= 5'd0;
      rs3_idx_r    <= 5'd0;
      rf_bad_reg_r <= 1'b0;
    end else if (!run_s) begin
      rf_valid_r <= 1'b0;
    end else if (flush) begin
      rf_valid_r <= 1'b0;
    end else if (!stall) begin
      rf_valid_r   <= valid;
      rf_pc_r      <= pc;
      rf_insn_r    <= insn;
      rs1_idx_r    <= insn[19:15];
      rs2_idx_r    <= insn[24:20];
      rs3_idx_r    <= insn[31:27];
      rf_bad_reg_r <= bad_s;
    end
  end

  // Operand read from the captured indices, so a stalled instruction sees later writebacks.
  always_comb begin
    rs1_s = sel_operand(rs1_idx_r, regs_r[rs1_idx_r[AW-1:0]],
                        (BYPASS != 0) && wb_we && (wb_rd == rs1_idx_r), wb_val);
    rs2_s = sel_operand(rs2_idx_r, regs_r[rs2_idx_r[AW-1:0]],
                        (BYPASS != 0) && wb_we && (wb_rd == rs2_idx_r), wb_val);
    if (RS3_EN != 0) begin
      rs3_s = sel_operand(rs3_idx_r, regs_r[rs3_idx_r[AW-1:0]],
                          (BYPASS != 0) && wb_we && (wb_rd == rs3_idx_r), wb_val);
    end else begin
      rs3_s = {XLEN{1'b0}};
    end
  end

  assign ready      = ready_r;
  assign rf_valid   = rf_valid_r;
  assign rf_pc      = rf_pc_r;
  assign rf_insn    = rf_insn_r;
  assign rf_rs1_val = rs1_s;
  assign rf_rs2_val = rs2_s;
  assign rf_rs3_val = rs3_s;
  assign rf_bad_reg = rf_bad_reg_r;

endmodule

// File: tb/tb_yarvi_regfile.sv
// Scoreboard bench: dut_a uses defaults (NREG=32, bypass), dut_e is RV32E with rs3 and no bypass.
module tb_yarvi_regfile;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        valid = 1'b0;
  logic [63:0] pc = 64'd0;
  logic [31:0] insn = 32'd0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [63:0] wb_val = 64'd0;

  logic        ready_a, rf_valid_a, rf_bad_reg_a;
  logic [63:0] rf_pc_a, rf_rs1_a, rf_rs2_a, rf_rs3_a;
  logic [31:0] rf_insn_a;
  logic        ready_e, rf_valid_e, rf_bad_reg_e;
  logic [63:0] rf_pc_e, rf_rs1_e, rf_rs2_e, rf_rs3_e;
  logic [31:0] rf_insn_e;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] rs3;
    logic        bad;
    logic [63:0] pc;
    logic [31:0] insn;
  } exp_t;

  exp_t qa[$];
  exp_t qe[$];

  localparam logic [63:0] X5 = 64'h1234_5678_9abc_def0;

  always #5 clock = ~clock;

  yarvi_regfile dut_a (
    .clock(clock), .reset_n(reset_n), .valid(valid), .pc(pc), .insn(insn),
    .stall(stall), .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_val(wb_val),
    .ready(ready_a), .rf_valid(rf_valid_a), .rf_pc(rf_pc_a), .rf_insn(rf_insn_a),
    .rf_rs1_val(rf_rs1_a), .rf_rs2_val(rf_rs2_a), .rf_rs3_val(rf_rs3_a),
    .rf_bad_reg(rf_bad_reg_a)
  );

  yarvi_regfile #(.XLEN(64), .VLEN(64), .NREG(16), .RS3_EN(1), .BYPASS(0)) dut_e (
    .clock(clock), .reset_n(reset_n), .valid(valid), .pc(pc), .insn(insn),
    .stall(stall), .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_val(wb_val),
    .ready(ready_e), .rf_valid(rf_valid_e), .rf_pc(rf_pc_e), .rf_insn(rf_insn_e),
    .rf_rs1_val(rf_rs1_e), .rf_rs2_val(rf_rs2_e), .rf_rs3_val(rf_rs3_e),
    .rf_bad_reg(rf_bad_reg_e)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] r3, input logic [4:0] r2,
                                     input logic [4:0] r1, input logic [4:0] rd);
    return {r3, 2'b00, r2, r1, 3'b000, rd, 7'b0110011};
  endfunction

  task automatic push(input logic [63:0] p, input logic [31:0] w,
                      input logic [63:0] a1, input logic [63:0] a2,
                      input logic [63:0] e1, input logic [63:0] e2, input logic [63:0] e3,
                      input logic eb);
    qa.push_back('{rs1: a1, rs2: a2, rs3: 64'd0, bad: 1'b0, pc: p, insn: w});
    qe.push_back('{rs1: e1, rs2: e2, rs3: e3, bad: eb, pc: p, insn: w});
  endtask

  task automatic cyc(input logic v, input logic [63:0] p, input logic [31:0] w,
                     input logic st, input logic fl, input logic we,
                     input logic [4:0] rd, input logic [63:0] val);
    valid = v; pc = p; insn = w; stall = st; flush = fl;
    wb_we = we; wb_rd = rd; wb_val = val;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
  endtask

  task automatic wr(input logic [4:0] rd, input logic [63:0] val);
    cyc(1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 1'b1, rd, val);
  endtask

  // Junk traffic during the clear walk must be ignored; it is removed before dut_e reaches RUN.
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready_a", {63'd0, ready_a}, 64'd0);
    chk("rst_ready_e", {63'd0, ready_e}, 64'd0);
    chk("rst_rf_valid_a", {63'd0, rf_valid_a}, 64'd0);
    chk("rst_rf_pc_a", rf_pc_a, 64'd0);
    chk("rst_rf_insn_a", {32'd0, rf_insn_a}, 64'd0);
    chk("rst_bad_e", {63'd0, rf_bad_reg_e}, 64'd0);
    reset_n = 1'b1;
    valid = 1'b1; insn = 32'hffff_ffff; pc = 64'hdead;
    wb_we = 1'b1; wb_rd = 5'd5; wb_val = 64'hbad;
    for (int n = 1; n <= 32; n++) begin
      @(posedge clock);
      #1;
      if (n == 14) begin
        valid = 1'b0; insn = 32'd0; pc = 64'd0; wb_we = 1'b0; wb_rd = 5'd0; wb_val = 64'd0;
      end
      if (n == 1)  chk("clr_ready_a_1", {63'd0, ready_a}, 64'd0);
      if (n == 15) chk("clr_ready_e_15", {63'd0, ready_e}, 64'd0);
      if (n == 16) chk("clr_ready_e_16", {63'd0, ready_e}, 64'd1);
      if (n == 31) chk("clr_ready_a_31", {63'd0, ready_a}, 64'd0);
      if (n == 32) chk("clr_ready_a_32", {63'd0, ready_a}, 64'd1);
    end
  endtask

  // Reads every index pair once; dut_e flags any field >= 16.
  task automatic readall();
    for (int i = 0; i < 16; i++) begin
      logic [31:0] w;
      logic [63:0] p;
      w = mk(5'd0, 5'(2 * i + 1), 5'(2 * i), 5'd0);
      p = 64'h1000 + 64'(4 * i);
      push(p, w, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, (i >= 8));
      cyc(1'b1, p, w, 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    end
    idle();
  endtask

  // Monitor: every live rf_valid presentation consumes one scoreboard entry per instance.
  always @(negedge clock) begin
    exp_t x;
    if (rf_valid_a === 1'b1) begin
      if (qa.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_unexpected_valid actual=1 expected=0 pc=%h", rf_pc_a);
      end else begin
        x = qa.pop_front();
        chk("a_pc", rf_pc_a, x.pc);
        chk("a_insn", {32'd0, rf_insn_a}, {32'd0, x.insn});
        chk("a_rs1", rf_rs1_a, x.rs1);
        chk("a_rs2", rf_rs2_a, x.rs2);
        chk("a_rs3", rf_rs3_a, x.rs3);
        chk("a_bad", {63'd0, rf_bad_reg_a}, {63'd0, x.bad});
      end
    end
    if (rf_valid_e === 1'b1) begin
      if (qe.size() == 0) begin
        checks++; failures++;
        $display("FAIL e_unexpected_valid actual=1 expected=0 pc=%h", rf_pc_e);
      end else begin
        x = qe.pop_front();
        chk("e_pc", rf_pc_e, x.pc);
        chk("e_insn", {32'd0, rf_insn_e}, {32'd0, x.insn});
        chk("e_rs1", rf_rs1_e, x.rs1);
        chk("e_rs2", rf_rs2_e, x.rs2);
        chk("e_rs3", rf_rs3_e, x.rs3);
        chk("e_bad", {63'd0, rf_bad_reg_e}, {63'd0, x.bad});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2;
    do_reset();
    readall();

    // Writes, then read back with rs3 on dut_e.
    wr(5'd5, X5);
    wr(5'd7, 64'h55);
    wr(5'd3, 64'h1111);
    wr(5'd1, 64'h11);
    push(64'h10, mk(5'd3, 5'd0, 5'd5, 5'd2), X5, 64'd0, X5, 64'd0, 64'h1111, 1'b0);
    cyc(1'b1, 64'h10, mk(5'd3, 5'd0, 5'd5, 5'd2), 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);

    // Bypass: x7 written in the cycle its reader is presented.
    push(64'h14, mk(5'd0, 5'd5, 5'd7, 5'd2), 64'haa, X5, 64'h55, X5, 64'd0, 1'b0);
    cyc(1'b1, 64'h14, mk(5'd0, 5'd5, 5'd7, 5'd2), 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    cyc(1'b0, 64'd0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd7, 64'haa);
    push(64'h18, mk(5'd0, 5'd7, 5'd7, 5'd0), 64'haa, 64'haa, 64'haa, 64'haa, 64'd0, 1'b0);
    cyc(1'b1, 64'h18, mk(5'd0, 5'd7, 5'd7, 5'd0), 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    idle();

    // Stall three cycles; x5 rewritten mid-stall.
    push(64'h100, mk(5'd0, 5'd0, 5'd5, 5'd1), X5, 64'd0, X5, 64'd0, 64'd0, 1'b0);
    push(64'h100, mk(5'd0, 5'd0, 5'd5, 5'd1), 64'h77, 64'd0, X5, 64'd0, 64'd0, 1'b0);
    push(64'h100, mk(5'd0, 5'd0, 5'd5, 5'd1), 64'h77, 64'd0, 64'h77, 64'd0, 64'd0, 1'b0);
    push(64'h100, mk(5'd0, 5'd0, 5'd5, 5'd1), 64'h77, 64'd0, 64'h77, 64'd0, 64'd0, 1'b0);
    cyc(1'b1, 64'h100, mk(5'd0, 5'd0, 5'd5, 5'd1), 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    cyc(1'b1, 64'h200, 32'h0000_0033, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0);
    cyc(1'b1, 64'h200, 32'h0000_0033, 1'b1, 1'b0, 1'b1, 5'd5, 64'h77);
    cyc(1'b1, 64'h200, 32'h0000_0033, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0);
    idle();

    // Stall and flush together kill the register.
    push(64'h300, mk(5'd0, 5'd0, 5'd0, 5'd0), 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
    cyc(1'b1, 64'h300, mk(5'd0, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    cyc(1'b1, 64'h400, mk(5'd0, 5'd2, 5'd1, 5'd0), 1'b1, 1'b1, 1'b0, 5'd0, 64'd0);
    chk("flush_rf_valid_a", {63'd0, rf_valid_a}, 64'd0);
    chk("flush_rf_valid_e", {63'd0, rf_valid_e}, 64'd0);
    idle();

    // x0 write is dropped.
    wr(5'd0, 64'hff);
    push(64'h1c, mk(5'd0, 5'd0, 5'd0, 5'd0), 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
    cyc(1'b1, 64'h1c, mk(5'd0, 5'd0, 5'd0, 5'd0), 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    idle();

    // x17: real on dut_a, dropped and aliased onto x1 on dut_e.
    wr(5'd17, 64'hdead);
    push(64'h20, mk(5'd0, 5'd17, 5'd1, 5'd0), 64'h11, 64'hdead, 64'h11, 64'h11, 64'd0, 1'b1);
    cyc(1'b1, 64'h20, mk(5'd0, 5'd17, 5'd1, 5'd0), 1'b0, 1'b0, 1'b0, 5'd0, 64'd0);
    idle();

    // Reset mid-run clears everything again.
    do_reset();
    readall();

    idle();
    idle();
    chk("a_queue_drained", 64'(qa.size()), 64'd0);
    chk("e_queue_drained", 64'(qe.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
